// File: rtl/alu_fifo_sequencer.sv
// Sequences one ALU operation per command: pop one or two operands from the
// shared FIFO, issue to the ALU, wait its latency, push the result back.
module alu_fifo_sequencer #(
  parameter int W       = 4,
  parameter int OPW     = 3,
  parameter int ALU_LAT = 1
) (
  input  logic           clk,
  input  logic           rstSync,
  input  logic           start,
  input  logic [OPW-1:0] opcode,
  input  logic           fifo_empty,
  input  logic           fifo_full,
  input  logic [W-1:0]   fifo_rdata,
  output logic           fifo_pop,
  output logic           fifo_push,
  output logic [W-1:0]   fifo_wdata,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  output logic           alu_go,
  input  logic [W-1:0]   alu_result,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [1:0]     err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_POP_A, S_POP_B, S_EXEC, S_WAIT, S_PUSH, S_DONE, S_ERR
  } state_t;

  // Opcodes at or above this value take a single operand.
  localparam logic [OPW-1:0] UNARY_MIN = OPW'(5);
  localparam logic [2:0]     LAT_CNT   = 3'(ALU_LAT);

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, result_q, result_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [2:0]       cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rstSync) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      result_q   <= '0;
      err_code_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      result_q   <= result_d;
      err_code_q <= err_code_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    result_d   = result_q;
    err_code_d = err_code_q;
    cnt_d      = cnt_q;
    fifo_pop   = 1'b0;
    fifo_push  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        op_d       = opcode;
        err_code_d = 2'b00;
        state_d    = S_POP_A;
      end
      S_POP_A: if (fifo_empty) begin
        err_code_d = 2'b01;
        state_d    = S_ERR;
      end else begin
        fifo_pop = 1'b1;
        a_d      = fifo_rdata;
        if (op_q >= UNARY_MIN) begin
          b_d     = '0;
          state_d = S_EXEC;
        end else begin
          state_d = S_POP_B;
        end
      end
      // A is already consumed if B underflows; it is not restored.
      S_POP_B: if (fifo_empty) begin
        err_code_d = 2'b10;
        state_d    = S_ERR;
      end else begin
        fifo_pop = 1'b1;
        b_d      = fifo_rdata;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        cnt_d = LAT_CNT;
        if (ALU_LAT == 0) begin
          result_d = alu_result;
          state_d  = S_PUSH;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          result_d = alu_result;
          state_d  = S_PUSH;
        end
      end
      S_PUSH: if (fifo_full) begin
        err_code_d = 2'b11;
        state_d    = S_ERR;
      end else begin
        fifo_push = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign fifo_wdata = result_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign alu_go     = (state_q == S_EXEC);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_alu_fifo_sequencer.sv
// Directed bench: three sequencers (ALU_LAT 1, 0, 7) share one FIFO model;
// only the selected instance sees start, and its strobes drive the FIFO.
module tb_alu_fifo_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstSync, start, force_full;
  logic [2:0] opcode;
  logic [3:0] mem [16];
  int         rd, wr, sel;
  logic       fifo_empty, fifo_full;
  logic [3:0] fifo_rdata;

  logic [2:0]       start_v, pop_v, push_v, go_v, busy_v, done_v, err_v;
  logic [2:0][3:0]  wdata_v, a_v, b_v, res_v;
  logic [2:0][2:0]  op_v;
  logic [2:0][1:0]  ec_v;

  assign fifo_empty = (rd == wr);
  assign fifo_full  = force_full || (wr - rd >= 8);
  assign fifo_rdata = mem[rd[3:0]];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 0 : 7;
    int         since = 0;
    logic [3:0] f;
    assign start_v[g] = start && (sel == g);
    always @(posedge clk)
      if (go_v[g]) since <= 1;
      else if (since != 0 && since < 15) since <= since + 1;
    always_comb begin
      case (op_v[g])
        3'd0:    f = a_v[g] + b_v[g];
        3'd5:    f = ~a_v[g];
        default: f = a_v[g] - b_v[g];
      endcase
    end
    // Result is only correct in the cycle the ALU latency says it is valid.
    assign res_v[g] = ((LAT == 0 && go_v[g]) || (LAT != 0 && since == LAT)) ? f : ~f;
    alu_fifo_sequencer #(.W(4), .OPW(3), .ALU_LAT(LAT)) dut (
      .clk(clk), .rstSync(rstSync), .start(start_v[g]), .opcode(opcode),
      .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_rdata(fifo_rdata),
      .fifo_pop(pop_v[g]), .fifo_push(push_v[g]), .fifo_wdata(wdata_v[g]),
      .alu_a(a_v[g]), .alu_b(b_v[g]), .alu_op(op_v[g]), .alu_go(go_v[g]),
      .alu_result(res_v[g]), .busy(busy_v[g]), .done(done_v[g]), .err(err_v[g]),
      .err_code(ec_v[g])
    );
  end

  logic [15:0] t_pop, t_push, t_go, t_busy, t_done, t_err;
  logic [3:0]  wd_push;
  logic [1:0]  ec1;
  int          n_cmp, n_bad;

  task automatic cyc(input int k, input logic st, input logic ff, input logic rs);
    logic sp, su;
    logic [3:0] sw;
    start = st; force_full = ff; rstSync = !rs;
    #1;
    if (k >= 0 && k < 16) begin
      t_pop[k] = pop_v[sel];  t_push[k] = push_v[sel]; t_go[k] = go_v[sel];
      t_busy[k] = busy_v[sel]; t_done[k] = done_v[sel]; t_err[k] = err_v[sel];
      if (push_v[sel]) wd_push = wdata_v[sel];
      if (k == 1) ec1 = ec_v[sel];
    end
    sp = pop_v[sel]; su = push_v[sel]; sw = wdata_v[sel];
    @(posedge clk); #1;
    if (sp) rd++;
    if (su) begin mem[wr[3:0]] = sw; wr++; end
  endtask

  task automatic load(input int n, input logic [3:0] d0, input logic [3:0] d1);
    rd = 0; wr = n;
    mem[0] = d0; mem[1] = d1;
  endtask

  task automatic run(input logic [2:0] op, input int n, input int spam_lo,
                     input int spam_hi, input int full_at);
    t_pop = 0; t_push = 0; t_go = 0; t_busy = 0; t_done = 0; t_err = 0;
    wd_push = 4'h0; ec1 = 2'bxx;
    opcode = op;
    for (int k = 0; k < n; k++)
      cyc(k, (k == 0) || (k >= spam_lo && k <= spam_hi), k == full_at, 1'b0);
  endtask

  task automatic test_reset;
    cyc(-1, 0, 0, 1); cyc(-1, 0, 0, 1);
    n_cmp++; if ({pop_v, push_v, go_v, busy_v, done_v, err_v} !== 18'h0) begin
      n_bad++; $display("FAIL reset_strobes got %h want 0", {pop_v, push_v, go_v, busy_v, done_v, err_v}); end
    n_cmp++; if ({a_v, b_v, op_v, wdata_v, ec_v} !== 51'h0) begin
      n_bad++; $display("FAIL reset_regs got %h want 0", {a_v, b_v, op_v, wdata_v, ec_v}); end
    cyc(-1, 0, 0, 0);
  endtask

  task automatic test_binary;
    sel = 0; load(2, 4'd3, 4'd5);
    run(3'b000, 9, 99, 99, 99);
    n_cmp++; if (t_pop !== 16'h0006) begin n_bad++; $display("FAIL bin_pop got %h want 0006", t_pop); end
    n_cmp++; if (t_go !== 16'h0008) begin n_bad++; $display("FAIL bin_go got %h want 0008", t_go); end
    n_cmp++; if (t_push !== 16'h0020) begin n_bad++; $display("FAIL bin_push got %h want 0020", t_push); end
    n_cmp++; if (t_done !== 16'h0040) begin n_bad++; $display("FAIL bin_done got %h want 0040", t_done); end
    n_cmp++; if (t_busy !== 16'h007E) begin n_bad++; $display("FAIL bin_busy got %h want 007e", t_busy); end
    n_cmp++; if ({a_v[0], b_v[0]} !== 8'h35) begin n_bad++; $display("FAIL bin_ops got %h want 35", {a_v[0], b_v[0]}); end
    n_cmp++; if (wd_push !== 4'h8 || mem[2] !== 4'h8 || wr - rd != 1) begin
      n_bad++; $display("FAIL bin_result got %h/%h want 8", wd_push, mem[2]); end
  endtask

  task automatic test_unary;
    sel = 0; load(1, 4'hA, 4'h0);
    run(3'b101, 8, 99, 99, 99);
    n_cmp++; if (t_pop !== 16'h0002) begin n_bad++; $display("FAIL un_pop got %h want 0002", t_pop); end
    n_cmp++; if (t_push !== 16'h0010 || t_done !== 16'h0020) begin
      n_bad++; $display("FAIL un_timing push %h done %h want 0010/0020", t_push, t_done); end
    n_cmp++; if (b_v[0] !== 4'h0) begin n_bad++; $display("FAIL un_b got %h want 0", b_v[0]); end
    n_cmp++; if (wd_push !== 4'h5) begin n_bad++; $display("FAIL un_result got %h want 5", wd_push); end
  endtask

  task automatic test_underflow;
    sel = 0; load(0, 4'h0, 4'h0);
    run(3'b000, 5, 99, 99, 99);
    n_cmp++; if (t_pop !== 16'h0 || t_err !== 16'h0004 || t_busy !== 16'h0006) begin
      n_bad++; $display("FAIL uf_a pop %h err %h busy %h want 0/0004/0006", t_pop, t_err, t_busy); end
    n_cmp++; if (ec_v[0] !== 2'b01) begin n_bad++; $display("FAIL uf_a_code got %b want 01", ec_v[0]); end
    load(1, 4'h7, 4'h0);
    run(3'b000, 5, 99, 99, 99);
    n_cmp++; if (t_pop !== 16'h0002 || t_err !== 16'h0008) begin
      n_bad++; $display("FAIL uf_b pop %h err %h want 0002/0008", t_pop, t_err); end
    n_cmp++; if (ec_v[0] !== 2'b10 || rd != wr) begin
      n_bad++; $display("FAIL uf_b_code got %b level %0d want 10/0", ec_v[0], wr - rd); end
  endtask

  task automatic test_overflow;
    sel = 0; load(2, 4'h6, 4'h4);
    run(3'b000, 8, 99, 99, 5);
    n_cmp++; if (t_push !== 16'h0 || t_err !== 16'h0040) begin
      n_bad++; $display("FAIL of_strobes push %h err %h want 0/0040", t_push, t_err); end
    n_cmp++; if (ec_v[0] !== 2'b11) begin n_bad++; $display("FAIL of_code got %b want 11", ec_v[0]); end
    n_cmp++; if (wdata_v[0] !== 4'hA) begin n_bad++; $display("FAIL of_retain got %h want a", wdata_v[0]); end
    load(2, 4'h1, 4'h2);
    run(3'b000, 8, 99, 99, 99);
    n_cmp++; if (ec1 !== 2'b00) begin n_bad++; $display("FAIL of_clear got %b want 00", ec1); end
    n_cmp++; if (wd_push !== 4'h3 || t_done !== 16'h0040) begin
      n_bad++; $display("FAIL of_next got %h done %h want 3/0040", wd_push, t_done); end
  endtask

  task automatic test_reset_mid;
    sel = 0; load(2, 4'h3, 4'h5);
    t_push = 0; t_busy = 0; opcode = 3'b010;
    for (int k = 0; k < 9; k++) cyc(k, k == 0, 1'b0, k == 4);
    n_cmp++; if (t_push !== 16'h0 || t_busy !== 16'h001E) begin
      n_bad++; $display("FAIL rm_trace push %h busy %h want 0/001e", t_push, t_busy); end
    n_cmp++; if ({a_v[0], b_v[0], op_v[0], wdata_v[0], ec_v[0]} !== 17'h0) begin
      n_bad++; $display("FAIL rm_regs got %h want 0", {a_v[0], b_v[0], op_v[0], wdata_v[0], ec_v[0]}); end
    n_cmp++; if (rd != 2 || wr != 2) begin n_bad++; $display("FAIL rm_fifo rd %0d wr %0d want 2/2", rd, wr); end
  endtask

  task automatic test_latency;
    sel = 1; load(2, 4'd3, 4'd5);
    run(3'b000, 8, 2, 4, 99);
    n_cmp++; if (t_go !== 16'h0008 || t_push !== 16'h0010 || t_done !== 16'h0020) begin
      n_bad++; $display("FAIL lat0 go %h push %h done %h want 0008/0010/0020", t_go, t_push, t_done); end
    n_cmp++; if (t_pop !== 16'h0006 || wd_push !== 4'h8) begin
      n_bad++; $display("FAIL lat0_data pop %h got %h want 0006/8", t_pop, wd_push); end
    sel = 2; load(2, 4'd3, 4'd5);
    run(3'b000, 14, 2, 6, 99);
    n_cmp++; if (t_push !== 16'h0800 || t_done !== 16'h1000 || t_busy !== 16'h1FFE) begin
      n_bad++; $display("FAIL lat7 push %h done %h busy %h want 0800/1000/1ffe", t_push, t_done, t_busy); end
    n_cmp++; if (t_pop !== 16'h0006 || wd_push !== 4'h8) begin
      n_bad++; $display("FAIL lat7_data pop %h got %h want 0006/8", t_pop, wd_push); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rstSync = 1'b0; start = 1'b0; force_full = 1'b0; opcode = 3'b000;
    sel = 0; rd = 0; wr = 0;
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    test_reset;
    test_binary;
    test_unary;
    test_underflow;
    test_overflow;
    test_reset_mid;
    test_latency;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_fifo_sequencer.md
Name: alu_fifo_sequencer

Overview:
- Sequences the shared operand FIFO and the ALU for one operation per command.
- On a start command it pops one or two operands from the FIFO head and issues the operation to the ALU. It waits the ALU latency, then pushes the result back into the FIFO.
- Sits between the push/toggle FIFO controller and the ALU. While busy it owns the FIFO pop/push strobes, and the manual controller must be gated off with `busy`.

Parameters:
- W, 4, operand/result data width in bits.
- OPW, 3, opcode width.
- ALU_LAT, 1, ALU result latency in cycles after `alu_go`; legal range 0..7.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rstSync  in  1  reset, synchronous, active-low (0 = reset).
- start  in  1  command strobe; sampled only in IDLE.
- opcode  in  OPW  operation; latched on an accepted start. Values >= 3'b101 are unary (one operand).
- fifo_empty  in  1  FIFO empty flag.
- fifo_full  in  1  FIFO full flag.
- fifo_rdata  in  W  FIFO head entry; combinational, valid when !fifo_empty.
- fifo_pop  out  1  one-cycle pop strobe; advances the read pointer.
- fifo_push  out  1  one-cycle push strobe; writes `fifo_wdata`.
- fifo_wdata  out  W  data to push (= `result_q`).
- alu_a  out  W  operand A register.
- alu_b  out  W  operand B register; 0 for unary ops.
- alu_op  out  OPW  latched opcode.
- alu_go  out  1  one-cycle issue strobe.
- alu_result  in  W  ALU result, valid ALU_LAT cycles after the `alu_go` cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on abort.
- err_code  out  2  00 none, 01 underflow on A, 10 underflow on B, 11 overflow on push. Held until the next accepted start.

Behaviour:

Reset:
- `rstSync`=0 at a rising edge forces IDLE and clears `a_q`, `b_q`, `op_q`, `result_q`, `err_code`, and the latency counter.
- All strobes, `busy`, `done` and `err` are 0 from the following cycle onward.
- Reset mid-operation aborts with no further pop/push. FIFO contents already popped are lost.

State machine (Moore strobes; all decoded from the present state):
- IDLE: `start`=1 latches `opcode` into `op_q`, clears `err_code`, goes to POP_A. `start` is ignored in every other state.
- POP_A:
  - If `fifo_empty`: go to ERR with code 01, no pop.
  - Otherwise: `fifo_pop`=1, `a_q`<=`fifo_rdata`.
  - Next state is POP_B for a binary op. For a unary op, clear `b_q` and go to EXEC.
- POP_B: if `fifo_empty`, go to ERR with code 10; A stays consumed. Otherwise `fifo_pop`=1, `b_q`<=`fifo_rdata`, go to EXEC.
- EXEC:
  - `alu_go`=1 and the counter loads ALU_LAT.
  - If ALU_LAT=0: `result_q`<=`alu_result` this cycle, go to PUSH.
  - Otherwise go to WAIT.
- WAIT: the counter decrements each cycle. In the cycle it equals 1, `result_q`<=`alu_result` and the state goes to PUSH. WAIT therefore lasts exactly ALU_LAT cycles.
- PUSH: if `fifo_full`, go to ERR with code 11 and do not push; `result_q` is retained. Otherwise `fifo_push`=1, go to DONE.
- DONE: `done`=1, go to IDLE.
- ERR: `err`=1, go to IDLE.

Timing:
- Binary op with ALU_LAT=1, start at cycle 0: POP_A c1, POP_B c2, EXEC c3, WAIT c4, PUSH c5, DONE c6, IDLE c7. `busy` is high c1..c6.
- Unary op: one cycle shorter.
- Back-to-back: a `start` held high in the DONE/ERR return cycle is not accepted. It is accepted in the IDLE cycle.

Data rules:
- At most one `fifo_pop` or `fifo_push` is asserted per cycle, and never both.
- `fifo_wdata` = `result_q`, held constant from PUSH onward until the next result is latched.
- Arithmetic belongs to the ALU; the sequencer applies no width changes.

Test Plan:
1. FIFO holds [3,5], opcode 000 (ADD), ALU model a+b mod 16, ALU_LAT=1, start at c0 -> `fifo_pop` at c1 and c2, `alu_a`=3, `alu_b`=5, `alu_go` at c3, `fifo_push` with `fifo_wdata`=8 at c5, `done` at c6, `busy` c1..c6.
2. FIFO holds [0xA], opcode 101 (unary NOT) -> single pop, `alu_b`=0, push 0x5, `done` one cycle earlier than scenario 1.
3. FIFO empty, start -> no pop, `err` at c2, `err_code`=01. Then FIFO [7], ADD -> one pop, `err_code`=10, FIFO empty afterward.
4. `fifo_full` forced high during PUSH -> no `fifo_push`, `err`=1, `err_code`=11, `result_q` retained. Next accepted start clears `err_code` to 00.
5. `rstSync`=0 in the WAIT cycle -> next cycle IDLE, `busy`=0, no push ever issued, all registers 0.
6. ALU_LAT=0 and ALU_LAT=7 with the same stimulus as scenario 1 -> EXEC directly followed by PUSH, respectively 7 WAIT cycles. The pushed value is 8 in both cases. `start` pulses while busy are ignored.
